// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, debouncer and press/release/long-press event FSM
// Long-press support (LONG_HELD state, hold counter, long_pulse) is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 24000000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic RELEASED_PIN = (BTN_ACTIVE_LOW != 0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;

    // Illegal parameter combinations leave a marker block in the elaborated hierarchy.
    if (DEBOUNCE_CYCLES < 2) begin : g_debounce_cycles_illegal
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_long_cycles_illegal
    end

    logic          sync_q1;
    logic          sync_q2;
    logic          pressed_sync;
    logic [DW-1:0] db_cnt;
    logic          accept;
    logic          accept_press;
    logic          accept_release;
    logic [1:0]    state;

    assign pressed_sync   = sync_q2 ^ RELEASED_PIN;
    assign accept         = (db_cnt == DB_MAX);
    assign accept_press   = accept && !btn_level;
    assign accept_release = accept && btn_level;

    // The counter saturates at DB_MAX for exactly one edge, which is the edge that flips btn_level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q1   <= RELEASED_PIN;
            sync_q2   <= RELEASED_PIN;
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
            if (accept) begin
                btn_level <= ~btn_level;
                db_cnt    <= '0;
            end else if (pressed_sync != btn_level) begin
                db_cnt <= db_cnt + DW'(1);
            end else begin
                db_cnt <= '0;
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_cnt;

    // Release is tested before the hold limit so a same-edge release suppresses long_pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_press) begin
                        state       <= ST_PRESSED;
                        hold_cnt    <= '0;
                        press_pulse <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (accept_release) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= ST_LONG;
                        hold_cnt   <= HOLD_MAX;
                        long_pulse <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_LONG: begin
                    if (accept_release) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign long_pulse = 1'b0;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_press) begin
                        state       <= ST_PRESSED;
                        press_pulse <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (accept_release) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule
